// File: rtl/class_hv_accumulator_pkg.sv
// Shared HDC definitions: default geometry, FSM state constants and width helper
// for the class hypervector accumulator.
package class_hv_accumulator_pkg;

  localparam int unsigned HDC_DIMS_PER_CC      = 1024;
  localparam int unsigned HDC_BITWIDTH_PER_DIM = 9;
  localparam int unsigned HDC_NUM_CHUNKS       = 4;
  localparam int unsigned HDC_NUM_CLASSES      = 4;

  localparam int unsigned STATE_W = 2;
  localparam logic [STATE_W-1:0] ST_IDLE    = 2'd0;
  localparam logic [STATE_W-1:0] ST_ACCUM   = 2'd1;
  localparam logic [STATE_W-1:0] ST_READOUT = 2'd2;

  // Index width that stays at least one bit wide for single-entry ranges.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/class_hv_accumulator_sat_counter_row.sv
// One chunk of one class hypervector: DIMS parallel unsigned counters, each
// incremented by its input bit and saturating at all-ones.
module hdc_sat_counter_row
  import class_hv_accumulator_pkg::*;
#(
  parameter int unsigned DIMS = HDC_DIMS_PER_CC,
  parameter int unsigned BW   = HDC_BITWIDTH_PER_DIM
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear_i,
  input  logic               inc_en_i,
  input  logic [DIMS-1:0]    bits_i,
  output logic [DIMS*BW-1:0] count_o
);

  localparam logic [BW-1:0] CNT_MAX = '1;

  logic [DIMS*BW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (inc_en_i) begin
      for (int d = 0; d < int'(DIMS); d++) begin
        if (bits_i[d] && (cnt_q[d*BW +: BW] != CNT_MAX)) begin
          cnt_d[d*BW +: BW] = cnt_q[d*BW +: BW] + BW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/class_hv_accumulator.sv
// Trains per-class saturating hypervector accumulators chunk by chunk and
// streams one class back out, a chunk per cycle, for thresholding.
module class_hv_accumulator
  import class_hv_accumulator_pkg::*;
#(
  parameter int unsigned DIMS_PER_CC      = HDC_DIMS_PER_CC,
  parameter int unsigned BITWIDTH_PER_DIM = HDC_BITWIDTH_PER_DIM,
  parameter int unsigned NUM_CHUNKS       = HDC_NUM_CHUNKS,
  parameter int unsigned NUM_CLASSES      = HDC_NUM_CLASSES
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    clear_all,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [clog2_min1(NUM_CLASSES)-1:0]      in_class,
  input  logic [DIMS_PER_CC-1:0]                  in_hv_chunk,
  input  logic                                    binarize_start,
  input  logic [clog2_min1(NUM_CLASSES)-1:0]      binarize_class,
  output logic                                    binarizing_class_hvs,
  output logic [DIMS_PER_CC*BITWIDTH_PER_DIM-1:0] class_thresholder_in,
  output logic [clog2_min1(NUM_CHUNKS)-1:0]       out_chunk_idx,
  output logic                                    binarize_done
);

  localparam int unsigned CHUNK_W = clog2_min1(NUM_CHUNKS);
  localparam int unsigned CLASS_W = clog2_min1(NUM_CLASSES);
  localparam int unsigned ROW_W   = DIMS_PER_CC * BITWIDTH_PER_DIM;
  localparam logic [CHUNK_W-1:0] LAST_CHUNK = CHUNK_W'(NUM_CHUNKS - 1);

  logic [STATE_W-1:0] state_q, state_d;
  logic [CHUNK_W-1:0] chunk_q, chunk_d;
  logic [CLASS_W-1:0] class_q, class_d;
  logic               accept_c;
  logic               clear_c;
  logic [CLASS_W-1:0] acc_class_c;
  logic [ROW_W-1:0]   row_cnt [NUM_CLASSES][NUM_CHUNKS];

  // Next-state: clear beats readout start, which beats a new sample in IDLE.
  always_comb begin
    state_d  = state_q;
    chunk_d  = chunk_q;
    class_d  = class_q;
    accept_c = 1'b0;
    clear_c  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (clear_all) begin
          clear_c = 1'b1;
        end else if (binarize_start) begin
          state_d = ST_READOUT;
          chunk_d = '0;
          class_d = binarize_class;
        end else if (in_valid) begin
          accept_c = 1'b1;
          class_d  = in_class;
          if (LAST_CHUNK != '0) begin
            state_d = ST_ACCUM;
            chunk_d = CHUNK_W'(1);
          end
        end
      end
      ST_ACCUM: begin
        if (in_valid) begin
          accept_c = 1'b1;
          if (chunk_q == LAST_CHUNK) begin
            state_d = ST_IDLE;
            chunk_d = '0;
          end else begin
            chunk_d = chunk_q + CHUNK_W'(1);
          end
        end
      end
      ST_READOUT: begin
        if (chunk_q == LAST_CHUNK) begin
          state_d = ST_IDLE;
          chunk_d = '0;
        end else begin
          chunk_d = chunk_q + CHUNK_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        chunk_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      chunk_q <= '0;
      class_q <= '0;
    end else begin
      state_q <= state_d;
      chunk_q <= chunk_d;
      class_q <= class_d;
    end
  end

  // The label is only taken from the first chunk; later chunks use the latch.
  assign acc_class_c = (state_q == ST_IDLE) ? in_class : class_q;

  for (genvar gc = 0; gc < NUM_CLASSES; gc++) begin : g_class
    for (genvar gk = 0; gk < NUM_CHUNKS; gk++) begin : g_chunk
      hdc_sat_counter_row #(
        .DIMS (DIMS_PER_CC),
        .BW   (BITWIDTH_PER_DIM)
      ) u_row (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (clear_c),
        .inc_en_i (accept_c && (acc_class_c == CLASS_W'(gc)) && (chunk_q == CHUNK_W'(gk))),
        .bits_i   (in_hv_chunk),
        .count_o  (row_cnt[gc][gk])
      );
    end
  end

  assign in_ready = ((state_q == ST_IDLE) && !clear_all && !binarize_start) ||
                    (state_q == ST_ACCUM);

  assign binarizing_class_hvs = (state_q == ST_READOUT);
  assign out_chunk_idx        = binarizing_class_hvs ? chunk_q : '0;
  assign binarize_done        = binarizing_class_hvs && (chunk_q == LAST_CHUNK);

  // Readout mux; forced to zero whenever no readout is in progress.
  always_comb begin
    class_thresholder_in = '0;
    for (int c = 0; c < int'(NUM_CLASSES); c++) begin
      for (int k = 0; k < int'(NUM_CHUNKS); k++) begin
        if (binarizing_class_hvs && (class_q == CLASS_W'(c)) && (chunk_q == CHUNK_W'(k))) begin
          class_thresholder_in = row_cnt[c][k];
        end
      end
    end
  end

endmodule

// File: tb/tb_class_hv_accumulator.sv
// Directed bench for class_hv_accumulator: a dimension-level model of the class
// counters plus a per-cycle schedule of expected readout chunks.
module tb_class_hv_accumulator;

  localparam int D    = 1024;
  localparam int BW   = 9;
  localparam int NCH  = 4;
  localparam int NCLS = 4;
  localparam int SAT  = 511;

  logic            clk = 1'b0;
  logic            rst;
  logic            clear_all;
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      in_class;
  logic [D-1:0]    in_hv_chunk;
  logic            binarize_start;
  logic [1:0]      binarize_class;
  logic            binarizing_class_hvs;
  logic [D*BW-1:0] class_thresholder_in;
  logic [1:0]      out_chunk_idx;
  logic            binarize_done;

  class_hv_accumulator dut (
    .clk                  (clk),
    .rst                  (rst),
    .clear_all            (clear_all),
    .in_valid             (in_valid),
    .in_ready             (in_ready),
    .in_class             (in_class),
    .in_hv_chunk          (in_hv_chunk),
    .binarize_start       (binarize_start),
    .binarize_class       (binarize_class),
    .binarizing_class_hvs (binarizing_class_hvs),
    .class_thresholder_in (class_thresholder_in),
    .out_chunk_idx        (out_chunk_idx),
    .binarize_done        (binarize_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int mdl [NCLS][NCH][D];
  int exp_cls [int];
  int exp_chk [int];
  logic [D-1:0] ones;
  logic [D-1:0] zeros;
  logic [D-1:0] alt;

  task automatic chk(input string name, input longint got, input longint expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, got, expv);
    end
  endtask

  // Per-cycle compare: either a scheduled readout chunk or the quiet output state.
  always @(negedge clk) begin
    if (!rst) begin
      if (exp_cls.exists(cyc)) begin
        int c, k, bad_d, bad_got, bad_exp;
        c = exp_cls[cyc];
        k = exp_chk[cyc];
        chk("rd_valid", binarizing_class_hvs, 1);
        chk("rd_idx", out_chunk_idx, k);
        chk("rd_done", binarize_done, (k == NCH - 1) ? 1 : 0);
        bad_d = -1; bad_got = 0; bad_exp = 0;
        for (int d = 0; d < D; d++) begin
          if (bad_d < 0 && int'(class_thresholder_in[d*BW +: BW]) != mdl[c][k][d]) begin
            bad_d = d;
            bad_got = int'(class_thresholder_in[d*BW +: BW]);
            bad_exp = mdl[c][k][d];
          end
        end
        checks++;
        if (bad_d >= 0) begin
          errors++;
          $display("FAIL rd_data cycle=%0d class=%0d chunk=%0d dim=%0d got=%0d expected=%0d",
                   cyc, c, k, bad_d, bad_got, bad_exp);
        end
      end else begin
        chk("quiet_valid", binarizing_class_hvs, 0);
        chk("quiet_idx", out_chunk_idx, 0);
        chk("quiet_done", binarize_done, 0);
        chk("quiet_data_zero", (class_thresholder_in == '0) ? 1 : 0, 1);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic model_zero();
    for (int c = 0; c < NCLS; c++)
      for (int k = 0; k < NCH; k++)
        for (int d = 0; d < D; d++) mdl[c][k][d] = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_zero();
    exp_cls.delete();
    exp_chk.delete();
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_valid", binarizing_class_hvs, 0);
    chk("rst_idx", out_chunk_idx, 0);
    chk("rst_done", binarize_done, 0);
    tick();
  endtask

  task automatic send_chunk(input int cls, input int k, input logic [D-1:0] pat);
    in_valid    = 1'b1;
    in_class    = (k == 0) ? 2'(cls) : 2'(cls + 1);
    in_hv_chunk = pat;
    @(negedge clk);
    chk("chunk_in_ready", in_ready, 1);
    for (int d = 0; d < D; d++)
      if (pat[d] && mdl[cls][k][d] < SAT) mdl[cls][k][d]++;
    tick();
    in_valid    = 1'b0;
    in_hv_chunk = '0;
  endtask

  task automatic send_sample(input int cls, input logic [D-1:0] p0, input logic [D-1:0] p1,
                             input logic [D-1:0] p2, input logic [D-1:0] p3, input int gap);
    send_chunk(cls, 0, p0); repeat (gap) tick();
    send_chunk(cls, 1, p1); repeat (gap) tick();
    send_chunk(cls, 2, p2); repeat (gap) tick();
    send_chunk(cls, 3, p3); repeat (gap) tick();
  endtask

  // Literal dim0/dim1 expectations on chunk 0 pin the model (-1 skips).
  task automatic readout(input int cls, input logic clr_during, input int lit0, input int lit1);
    binarize_start = 1'b1;
    binarize_class = 2'(cls);
    for (int k = 0; k < NCH; k++) begin
      exp_cls[cyc + 1 + k] = cls;
      exp_chk[cyc + 1 + k] = k;
    end
    @(negedge clk);
    chk("start_in_ready", in_ready, 0);
    tick();
    binarize_start = 1'b0;
    clear_all      = clr_during;
    for (int k = 0; k < NCH; k++) begin
      @(negedge clk);
      chk("lit_idx", out_chunk_idx, k);
      chk("rd_in_ready", in_ready, 0);
      if (k == 0 && lit0 >= 0) chk("lit_dim0", class_thresholder_in[0 +: BW], lit0);
      if (k == 0 && lit1 >= 0) chk("lit_dim1", class_thresholder_in[BW +: BW], lit1);
      tick();
    end
    clear_all = 1'b0;
  endtask

  task automatic do_clear();
    clear_all = 1'b1;
    @(negedge clk);
    chk("clear_in_ready", in_ready, 0);
    tick();
    clear_all = 1'b0;
    model_zero();
  endtask

  initial begin
    ones  = '1;
    zeros = '0;
    for (int d = 0; d < D; d++) alt[d] = (d % 2 == 1);
    rst = 1'b1; clear_all = 1'b0; in_valid = 1'b0; in_class = '0; in_hv_chunk = '0;
    binarize_start = 1'b0; binarize_class = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // One all-ones sample to class 2, then read it back.
    send_sample(2, ones, ones, ones, ones, 0);
    readout(2, 1'b0, 1, 1);
    readout(0, 1'b0, 0, 0);

    // Alternating chunk 0 to class 1 with input gaps.
    do_reset();
    send_sample(1, alt, zeros, zeros, zeros, 3);
    for (int c = 0; c < NCLS; c++) readout(c, 1'b0, (c == 1) ? 0 : 0, (c == 1) ? 1 : 0);

    // Saturation at 511 after 600 all-ones samples.
    for (int i = 0; i < 600; i++) send_sample(0, ones, ones, ones, ones, 0);
    readout(0, 1'b0, SAT, SAT);

    // Start and in_valid in the same IDLE cycle: readout first, sample afterwards.
    binarize_start = 1'b1;
    binarize_class = 2'd1;
    in_valid       = 1'b1;
    in_class       = 2'd3;
    in_hv_chunk    = ones;
    for (int k = 0; k < NCH; k++) begin
      exp_cls[cyc + 1 + k] = 1;
      exp_chk[cyc + 1 + k] = k;
    end
    @(negedge clk);
    chk("race_in_ready", in_ready, 0);
    tick();
    binarize_start = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      @(negedge clk);
      chk("race_rd_in_ready", in_ready, 0);
      tick();
    end
    send_sample(3, ones, alt, ones, zeros, 1);
    readout(3, 1'b0, 1, 1);

    // Clear ignored during readout, honoured in IDLE.
    readout(0, 1'b1, SAT, SAT);
    do_clear();
    for (int c = 0; c < NCLS; c++) readout(c, 1'b0, 0, 0);

    // Reset after chunk 1; a start during ACCUM must be ignored.
    send_chunk(2, 0, ones);
    binarize_start = 1'b1;
    binarize_class = 2'd2;
    send_chunk(2, 1, ones);
    binarize_start = 1'b0;
    do_reset();
    readout(2, 1'b0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
